y86_fetch_buffer: RTL
=====================

// Module: y86_fetch_buffer
// PURPOSE
// Fetch stage directly upstream of the SEQ decoder. Given a PC, reads 64-bit words from
// instruction memory and assembles the 10-byte window at PC into instruction[0:79].
// instruction[0:7] is the byte at PC, [8:15] is PC+1, and so on up to [72:79] = PC+9.
// The window and imem_error are handed to the decoder over a valid/ready handshake.
// PARAMETERS
// MEM_BYTES  4096  instruction memory size in bytes (multiple of 8); PC >= MEM_BYTES is an error
// PORTS
// clock        in   1   rising-edge clock
// reset        in   1   synchronous, active-high
// fetch_start  in   1   pulse: begin fetch at pc (accepted only in IDLE)
// pc           in   64  byte address of instruction, sampled with fetch_start
// flush        in   1   abort current fetch; return to IDLE
// busy         out  1   high in any state other than IDLE
// mem_req      out  1   memory read request
// mem_addr     out  61  word address (byte address >> 3)
// mem_rdata    in   64  read data; byte k of the word is on [8k+7:8k] (little-endian)
// mem_valid    in   1   response; counts only when mem_req && mem_valid
// mem_error    in   1   qualified with mem_valid; word read failed
// instr_valid  out  1   instruction/imem_error valid
// instr_ready  in   1   decoder accepts when instr_valid && instr_ready
// instruction  out  80  assembled bytes, [0:79] big-endian byte order
// imem_error   out  1   PC out of range or any mem_error during this fetch
// BEHAVIOUR
// - Reset: state IDLE; busy, mem_req, instr_valid, imem_error = 0; mem_addr, instruction = 0.
// - States: IDLE, REQ, OUT, DRAIN.
// - IDLE: on fetch_start && !flush, latch pc, set offset o = pc[2:0], word count n = (o>=7)?3:2,
//   word index i = 0, clear byte buffer and error flag; go REQ. flush wins over fetch_start.
// - PC check at start: if pc >= MEM_BYTES, set imem_error, skip memory, go OUT next cycle.
// - REQ: mem_req=1, mem_addr = pc[63:3]+i. On mem_req&&mem_valid: store the word's bytes
//   that fall in [pc, pc+9]; OR mem_error into error flag; i++. If i reaches n, or the next
//   word address >= MEM_BYTES/8, go OUT. Bytes from unrequested words read as 8'h00.
// - mem_valid may be high in the same cycle mem_req rises (zero-wait memory). mem_req stays
//   high across back-to-back words; mem_addr updates the cycle after each accepted response.
// - Once raised, mem_req does not drop until the response is accepted. One outstanding request.
// - OUT: instr_valid=1; instruction and imem_error held stable until instr_ready. On
//   instr_valid&&instr_ready go IDLE and deassert instr_valid the next cycle.
// - Latency with zero-wait memory: fetch_start sampled at edge 0 -> instr_valid high in
//   cycle n+1 (3 cycles for o<=6, 4 cycles for o=7). Wait states add cycle-for-cycle.
// - flush in REQ with the request not yet answered: go DRAIN (mem_req held, addr unchanged);
//   absorb and discard the response, then go IDLE. If mem_valid is high in the same cycle as
//   flush, the response is discarded and the next state is IDLE.
// - flush in OUT: drop instr_valid, go IDLE, and assert no handshake.
// - fetch_start outside IDLE is ignored. Do not queue it.
// - reset mid-fetch: return to reset state immediately. Memory side must tolerate the
//   abandoned request.
// - Word address arithmetic is 61-bit and wraps silently. The range check prevents wrapped
//   words from being requested.
// TESTING
// - mem[0..15]=00 f1 01 02 03 04 05 06 07 08 ...; pc=0, zero-wait -> words 0,1 requested;
//   instruction=80'h00f10102030405060708, imem_error=0, instr_valid in cycle 3.
// - Bytes at 0x17..0x20 = 30 f3 41 02 03 04 05 06 07 09; pc=0x17 -> words 2,3,4 requested;
//   instruction=80'h30f34102030405060709, instr_valid in cycle 4.
// - pc=MEM_BYTES -> no mem_req; instr_valid after 1 cycle with imem_error=1.
//   pc=MEM_BYTES-2 -> one word read; instruction[16:79]=0, imem_error=0.
// - mem_error=1 on second word of pc=8 fetch -> imem_error=1, instr_valid still asserted
//   after word 2 completes.
// - Memory with 3 wait states, flush one cycle after mem_req rises -> mem_req held until
//   mem_valid; state DRAIN then IDLE; no instr_valid. A new fetch_start then completes normally.
// - instr_ready held low 5 cycles in OUT -> instruction/imem_error stable; fetch_start pulses
//   ignored; single handshake when ready rises; busy drops the following cycle.

Source files
------------

// File: rtl/y86_fetch_buffer.sv
// Y86 fetch stage: gathers the 10-byte instruction window at PC from
// 64-bit instruction memory and hands it to the decoder over valid/ready.
module y86_fetch_buffer #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [63:0] pc,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [60:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_error,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [0:79] instruction,
  output logic        imem_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_DRAIN
  } state_t;

  localparam logic [63:0] LP_LIMIT  = 64'(MEM_BYTES);
  localparam logic [60:0] LP_WLIMIT = 61'(MEM_BYTES / 8);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_off;
  logic [1:0]  r_n;
  logic [1:0]  r_i;
  logic [60:0] r_addr;
  logic [0:79] r_buf;
  logic        r_err;

  logic        w_start;
  logic        w_pc_bad;
  logic        w_acc;
  logic [1:0]  w_i_inc;
  logic        w_last;
  logic [4:0]  w_idx;
  logic [0:79] w_buf_nxt;

  assign w_start  = (r_state == S_IDLE) && fetch_start && !flush;
  assign w_pc_bad = (pc >= LP_LIMIT);
  assign w_acc    = (r_state == S_REQ) && mem_valid && !flush;
  assign w_i_inc  = r_i + 2'd1;
  assign w_last   = (w_i_inc == r_n) ||
                    ((r_addr + 61'd1) >= LP_WLIMIT);

  // Window byte j lives at word (j+off)>>3, lane (j+off)&7.
  always_comb begin
    w_buf_nxt = r_buf;
    w_idx     = '0;
    for (int j = 0; j < 10; j++) begin
      w_idx = 5'(j) + {2'b00, r_off};
      if (w_idx[4:3] == r_i)
        w_buf_nxt[8*j +: 8] = mem_rdata[{w_idx[2:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = w_pc_bad ? S_OUT : S_REQ;
      end
      S_REQ: begin
        if (flush)
          w_state_nxt = mem_valid ? S_IDLE : S_DRAIN;
        else if (mem_valid && w_last)
          w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (flush || instr_ready) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    mem_req     = (r_state == S_REQ) || (r_state == S_DRAIN);
    instr_valid = (r_state == S_OUT) && !flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_off  <= '0;
      r_n    <= '0;
      r_i    <= '0;
      r_addr <= '0;
      r_buf  <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_off  <= pc[2:0];
      r_n    <= (pc[2:0] == 3'd7) ? 2'd3 : 2'd2;
      r_i    <= '0;
      r_addr <= pc[63:3];
      r_buf  <= '0;
      r_err  <= w_pc_bad;
    end else if (w_acc) begin
      r_buf <= w_buf_nxt;
      r_err <= r_err | mem_error;
      r_i   <= w_i_inc;
      if (!w_last) r_addr <= r_addr + 61'd1;
    end
  end

  assign mem_addr    = r_addr;
  assign instruction = r_buf;
  assign imem_error  = r_err;

endmodule
